// File: rtl/uart_cmd_parser.sv
// Frame parser for SYNC/CMD/LEN/payload[/CHK] commands from a UART receiver, with a valid/ack command handshake.
// Define UART_CMD_PARSER_CHECKSUM_EN to require and verify a trailing modulo-256 checksum byte.
module uart_cmd_parser #(
    parameter logic [7:0] SYNC_BYTE = 8'hA5,
    parameter int         MAX_LEN   = 16,
    parameter int         ADDR_W    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_ready,
    input  logic              rx_endofpacket,
    output logic              cmd_valid,
    input  logic              cmd_ack,
    output logic [7:0]        cmd_code,
    output logic [7:0]        cmd_len,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data,
    output logic              err_chk,
    output logic              err_len,
    output logic              err_abort,
    output logic [7:0]        drop_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_LEN,
        S_DATA,
`ifdef UART_CMD_PARSER_CHECKSUM_EN
        S_CHK,
`endif
        S_HOLD
    } state_e;

    // State entered once the final payload byte (or a zero LEN) has been taken.
`ifdef UART_CMD_PARSER_CHECKSUM_EN
    localparam state_e S_END = S_CHK;
`else
    localparam state_e S_END = S_HOLD;
`endif

    localparam logic [7:0]      MAX_LEN_B = 8'(MAX_LEN);
    localparam logic [ADDR_W:0] MAX_LEN_A = (ADDR_W + 1)'(MAX_LEN);

    state_e            state_q, state_d;
    logic [7:0]        code_q, code_d;
    logic [7:0]        len_q, len_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [7:0]        drop_q, drop_d;
    logic              err_len_q, err_len_d;
    logic              err_abort_q, err_abort_d;
    logic [7:0]        rd_data_q, rd_data_d;
    logic              buf_we;
    logic [7:0]        buf_mem [2**ADDR_W];
`ifdef UART_CMD_PARSER_CHECKSUM_EN
    logic [7:0]        sum_q, sum_d;
    logic              err_chk_q, err_chk_d;
`endif

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case leaves one unassigned (no latches).
        state_d     = state_q;
        code_d      = code_q;
        len_d       = len_q;
        idx_d       = idx_q;
        drop_d      = drop_q;
        err_len_d   = 1'b0;
        err_abort_d = 1'b0;
        buf_we      = 1'b0;
`ifdef UART_CMD_PARSER_CHECKSUM_EN
        sum_d       = sum_q;
        err_chk_d   = 1'b0;
`endif
        case (state_q)
            S_IDLE: if (rx_ready && rx_data == SYNC_BYTE) state_d = S_CMD;
            S_CMD: if (rx_ready) begin
                code_d  = rx_data;
`ifdef UART_CMD_PARSER_CHECKSUM_EN
                sum_d   = rx_data;
`endif
                state_d = S_LEN;
            end
            S_LEN: if (rx_ready) begin
                if (rx_data > MAX_LEN_B) begin
                    err_len_d = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    len_d   = rx_data;
                    idx_d   = '0;
`ifdef UART_CMD_PARSER_CHECKSUM_EN
                    sum_d   = sum_q + rx_data;
`endif
                    state_d = (rx_data != 8'd0) ? S_DATA : S_END;
                end
            end
            S_DATA: if (rx_ready) begin
                buf_we = 1'b1;
                idx_d  = idx_q + 1'b1;
`ifdef UART_CMD_PARSER_CHECKSUM_EN
                sum_d  = sum_q + rx_data;
`endif
                if (8'(idx_q) == len_q - 8'd1) state_d = S_END;
            end
`ifdef UART_CMD_PARSER_CHECKSUM_EN
            S_CHK: if (rx_ready) begin
                if (rx_data == sum_q) begin
                    state_d = S_HOLD;
                end else begin
                    err_chk_d = 1'b1;
                    state_d   = S_IDLE;
                end
            end
`endif
            S_HOLD: begin
                if (rx_ready && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
                if (cmd_ack) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // A line gap only aborts a frame in progress, and a byte arriving with it wins.
        if (rx_endofpacket && !rx_ready && state_q != S_IDLE && state_q != S_HOLD) begin
            err_abort_d = 1'b1;
            state_d     = S_IDLE;
        end

        rd_data_d = ({1'b0, rd_addr} >= MAX_LEN_A) ? 8'h00 : buf_mem[rd_addr];
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q     <= S_IDLE;
            code_q      <= 8'h00;
            len_q       <= 8'h00;
            idx_q       <= '0;
            drop_q      <= 8'h00;
            err_len_q   <= 1'b0;
            err_abort_q <= 1'b0;
            rd_data_q   <= 8'h00;
`ifdef UART_CMD_PARSER_CHECKSUM_EN
            sum_q       <= 8'h00;
            err_chk_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            code_q      <= code_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            drop_q      <= drop_d;
            err_len_q   <= err_len_d;
            err_abort_q <= err_abort_d;
            rd_data_q   <= rd_data_d;
`ifdef UART_CMD_PARSER_CHECKSUM_EN
            sum_q       <= sum_d;
            err_chk_q   <= err_chk_d;
`endif
        end
    end

    // NOTE: the payload buffer has no reset; it is only meaningful while cmd_valid is high.
    always_ff @(posedge clk) begin
        if (buf_we) buf_mem[idx_q] <= rx_data;
    end

    assign cmd_valid = (state_q == S_HOLD);
    assign cmd_code  = code_q;
    assign cmd_len   = len_q;
    assign rd_data   = rd_data_q;
    assign err_len   = err_len_q;
    assign err_abort = err_abort_q;
    assign drop_cnt  = drop_q;
`ifdef UART_CMD_PARSER_CHECKSUM_EN
    assign err_chk   = err_chk_q;
`else
    assign err_chk   = 1'b0;
`endif

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Scoreboard bench for uart_cmd_parser: expected commands/error pulses are queued as frames are sent, a monitor pops them.
// Honours UART_CMD_PARSER_CHECKSUM_EN the same way as the design (CHK byte appended and bad-checksum case added).
module tb_uart_cmd_parser;

    typedef enum logic [1:0] {EV_VALID, EV_CHK, EV_LEN, EV_ABORT} ev_kind_e;
    typedef struct {
        ev_kind_e   kind;
        logic [7:0] code;
        logic [7:0] len;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       rx_endofpacket;
    logic       cmd_valid;
    logic       cmd_ack;
    logic [7:0] cmd_code;
    logic [7:0] cmd_len;
    logic [4:0] rd_addr;
    logic [7:0] rd_data;
    logic       err_chk;
    logic       err_len;
    logic       err_abort;
    logic [7:0] drop_cnt;

    int         n_checks = 0;
    int         n_errors = 0;
    ev_t        exp_q[$];
    logic [7:0] pl [16];

    uart_cmd_parser #(.SYNC_BYTE(8'hA5), .MAX_LEN(16), .ADDR_W(5)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_ready(rx_ready),
        .rx_endofpacket(rx_endofpacket), .cmd_valid(cmd_valid), .cmd_ack(cmd_ack),
        .cmd_code(cmd_code), .cmd_len(cmd_len), .rd_addr(rd_addr), .rd_data(rd_data),
        .err_chk(err_chk), .err_len(err_len), .err_abort(err_abort), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_ev(input ev_kind_e kind, input logic [7:0] code, input logic [7:0] len);
        ev_t e;
        e.kind = kind;
        e.code = code;
        e.len  = len;
        exp_q.push_back(e);
    endtask

    task automatic observe(input ev_kind_e kind);
        ev_t e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_event: got %s, expected none", kind.name());
        end else begin
            e = exp_q.pop_front();
            check("event_kind", 32'(kind), 32'(e.kind));
            if (e.kind == EV_VALID && kind == EV_VALID) begin
                check("event_cmd_code", 32'(cmd_code), 32'(e.code));
                check("event_cmd_len", 32'(cmd_len), 32'(e.len));
            end
        end
    endtask

    task automatic monitor();
        logic valid_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (cmd_valid && !valid_prev) observe(EV_VALID);
            if (err_chk) observe(EV_CHK);
            if (err_len) observe(EV_LEN);
            if (err_abort) observe(EV_ABORT);
            valid_prev = cmd_valid;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_ready = 1'b1;
        @(posedge clk);
        #1;
        rx_ready = 1'b0;
    endtask

    task automatic pulse_eop();
        rx_endofpacket = 1'b1;
        @(posedge clk);
        #1;
        rx_endofpacket = 1'b0;
    endtask

    // Sends a well-formed frame using pl[0..len-1] and queues the expected command.
    task automatic send_frame(input logic [7:0] code, input logic [7:0] len);
`ifdef UART_CMD_PARSER_CHECKSUM_EN
        logic [7:0] sum;
        sum = code + len;
`endif
        expect_ev(EV_VALID, code, len);
        send_byte(8'hA5);
        send_byte(code);
        send_byte(len);
        for (int i = 0; i < int'(len); i++) begin
            send_byte(pl[i[3:0]]);
`ifdef UART_CMD_PARSER_CHECKSUM_EN
            sum = sum + pl[i[3:0]];
`endif
        end
`ifdef UART_CMD_PARSER_CHECKSUM_EN
        send_byte(sum);
`endif
    endtask

    task automatic ack_cmd();
        cmd_ack = 1'b1;
        @(posedge clk);
        #1;
        cmd_ack = 1'b0;
        check("valid_low_after_ack", 32'(cmd_valid), 32'h0);
    endtask

    task automatic read_chk(input string name, input logic [4:0] addr, input logic [7:0] exp);
        rd_addr = addr;
        @(posedge clk);
        #1;
        check(name, 32'(rd_data), 32'(exp));
    endtask

    initial begin
        rst = 1'b1;
        rx_data = 8'h00;
        rx_ready = 1'b0;
        rx_endofpacket = 1'b0;
        cmd_ack = 1'b0;
        rd_addr = '0;
        fork
            monitor();
            begin
                #200000;
                $display("FAIL watchdog: simulation time limit reached");
                $fatal(1, "watchdog");
            end
        join_none

        repeat (2) @(posedge clk);
        #1;
        check("reset_cmd_valid", 32'(cmd_valid), 32'h0);
        check("reset_cmd_code", 32'(cmd_code), 32'h0);
        check("reset_cmd_len", 32'(cmd_len), 32'h0);
        check("reset_drop_cnt", 32'(drop_cnt), 32'h0);
        check("reset_rd_data", 32'(rd_data), 32'h0);
        check("reset_errs", 32'({err_chk, err_len, err_abort}), 32'h0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Good frame A5 10 02 33 44 [89]
        pl[0] = 8'h33; pl[1] = 8'h44;
        send_frame(8'h10, 8'h02);
        check("good_valid", 32'(cmd_valid), 32'h1);
        check("good_code", 32'(cmd_code), 32'h10);
        check("good_len", 32'(cmd_len), 32'h2);
        read_chk("good_rd0", 5'd0, 8'h33);
        read_chk("good_rd1", 5'd1, 8'h44);
        read_chk("rd_out_of_range", 5'd20, 8'h00);
        ack_cmd();

`ifdef UART_CMD_PARSER_CHECKSUM_EN
        // Bad checksum A5 10 02 33 44 88
        expect_ev(EV_CHK, 8'h00, 8'h00);
        send_byte(8'hA5); send_byte(8'h10); send_byte(8'h02);
        send_byte(8'h33); send_byte(8'h44); send_byte(8'h88);
        check("badchk_no_valid", 32'(cmd_valid), 32'h0);
        @(posedge clk);
        #1;
`endif
        // Ack while idle is ignored; then a good frame A5 30 01 77 [A8]
        cmd_ack = 1'b1;
        @(posedge clk);
        #1;
        cmd_ack = 1'b0;
        pl[0] = 8'h77;
        send_frame(8'h30, 8'h01);
        check("after_err_valid", 32'(cmd_valid), 32'h1);
        read_chk("after_err_rd0", 5'd0, 8'h77);
        ack_cmd();

        // LEN too large A5 20 11, then stray bytes ignored in IDLE
        expect_ev(EV_LEN, 8'h00, 8'h00);
        send_byte(8'hA5); send_byte(8'h20); send_byte(8'h11);
        send_byte(8'h10); send_byte(8'h02); send_byte(8'h33); send_byte(8'h44);
        check("len_err_no_valid", 32'(cmd_valid), 32'h0);

        // LEN == MAX_LEN boundary: A5 21 10 00..0F [A9]
        for (int i = 0; i < 16; i++) pl[i] = 8'(i);
        send_frame(8'h21, 8'h10);
        check("maxlen_valid", 32'(cmd_valid), 32'h1);
        read_chk("maxlen_rd15", 5'd15, 8'h0F);
        read_chk("maxlen_rd16", 5'd16, 8'h00);
        ack_cmd();

        // Gap abort mid-frame, then gap in IDLE is ignored
        expect_ev(EV_ABORT, 8'h00, 8'h00);
        send_byte(8'hA5); send_byte(8'h10); send_byte(8'h02); send_byte(8'h33);
        pulse_eop();
        @(posedge clk);
        #1;
        pulse_eop();
        check("abort_no_valid", 32'(cmd_valid), 32'h0);

        // Byte coincident with gap is processed: A5 11 01 55 [67]
        expect_ev(EV_VALID, 8'h11, 8'h01);
        send_byte(8'hA5); send_byte(8'h11); send_byte(8'h01);
        rx_endofpacket = 1'b1;
        send_byte(8'h55);
        rx_endofpacket = 1'b0;
`ifdef UART_CMD_PARSER_CHECKSUM_EN
        send_byte(8'h67);
`endif
        check("coincident_valid", 32'(cmd_valid), 32'h1);
        read_chk("coincident_rd0", 5'd0, 8'h55);
        ack_cmd();

        // Bytes during HOLD: A5 42 03 01 02 03 [4B], then 300 dropped bytes and a gap
        pl[0] = 8'h01; pl[1] = 8'h02; pl[2] = 8'h03;
        send_frame(8'h42, 8'h03);
        for (int i = 0; i < 100; i++) send_byte(i[7:0]);
        check("drop_cnt_100", 32'(drop_cnt), 32'd100);
        for (int i = 100; i < 300; i++) send_byte(i[7:0]);
        pulse_eop();
        check("drop_cnt_sat", 32'(drop_cnt), 32'd255);
        check("hold_valid", 32'(cmd_valid), 32'h1);
        check("hold_code", 32'(cmd_code), 32'h42);
        check("hold_len", 32'(cmd_len), 32'h3);
        read_chk("hold_rd0", 5'd0, 8'h01);
        read_chk("hold_rd2", 5'd2, 8'h03);
        ack_cmd();

        // Zero-length frame A5 07 00 [07]
        send_frame(8'h07, 8'h00);
        check("zero_len_valid", 32'(cmd_valid), 32'h1);
        check("zero_len_len", 32'(cmd_len), 32'h0);
        ack_cmd();

        // Reset while in DATA
        rd_addr = 5'd0;
        send_byte(8'hA5); send_byte(8'h10); send_byte(8'h04); send_byte(8'h01); send_byte(8'h02);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_data_valid", 32'(cmd_valid), 32'h0);
        check("rst_data_code", 32'(cmd_code), 32'h0);
        check("rst_data_len", 32'(cmd_len), 32'h0);
        check("rst_data_drop", 32'(drop_cnt), 32'h0);
        check("rst_data_rd", 32'(rd_data), 32'h0);
        rst = 1'b0;
        pl[0] = 8'h55;
        send_frame(8'h10, 8'h01);
        check("post_rst_valid", 32'(cmd_valid), 32'h1);
        read_chk("post_rst_rd0", 5'd0, 8'h55);
        ack_cmd();

        repeat (4) @(posedge clk);
        #1;
        check("pending_events", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
